// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO family.
package fifo_pkg;

    localparam int FIFO_DATA_BITS_DEFAULT = 8;

    // A FIFO of 2**depth_bits entries needs one extra bit to count from 0 to full.
    function automatic int fifo_level_bits(input int depth_bits);
        return depth_bits + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array for the FIFO family: one synchronous write port, one asynchronous read port.
// No reset: contents are meaningless until written, and a flush leaves them untouched.
module fifo_ram #(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 2
) (
    input  logic                 clock,
    input  logic                 write_en,
    input  logic [ADDR_BITS-1:0] write_addr,
    input  logic [DATA_BITS-1:0] write_data,
    input  logic [ADDR_BITS-1:0] read_addr,
    output logic [DATA_BITS-1:0] read_data
);

    logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

    // Store the accepted write on the rising edge.
    always_ff @(posedge clock) begin
        if (write_en) begin
            mem[write_addr] <= write_data;
        end
    end

    assign read_data = mem[read_addr];

endmodule

// File: rtl/fifo_level.sv
// Single-clock first-word-fall-through FIFO with fill level, almost-full/almost-empty
// flags, synchronous flush and overflow/underflow error outputs.
// Build option: define FIFO_STICKY_ERRORS_EN to make the error outputs sticky until
// error_clear_i; otherwise they are same-cycle pulses and error_clear_i is unused.
module fifo_level
    import fifo_pkg::*;
#(
    parameter int DATA_BITS    = FIFO_DATA_BITS_DEFAULT,
    parameter int DEPTH_BITS   = 2,
    parameter int AFULL_LEVEL  = 3,
    parameter int AEMPTY_LEVEL = 1
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   flush_i,
    input  logic                                   write_i,
    input  logic [DATA_BITS-1:0]                   write_data_i,
    output logic                                   write_ready_o,
    input  logic                                   read_i,
    output logic [DATA_BITS-1:0]                   read_data_o,
    output logic                                   read_ready_o,
    output logic [fifo_level_bits(DEPTH_BITS)-1:0] level_o,
    output logic                                   almost_full_o,
    output logic                                   almost_empty_o,
    input  logic                                   error_clear_i,
    output logic                                   error_overflow_o,
    output logic                                   error_underflow_o
);

    localparam int LB = fifo_level_bits(DEPTH_BITS);
    localparam logic [LB-1:0] CAPACITY = LB'(2 ** DEPTH_BITS);
    localparam logic [LB-1:0] AFULL_L  = LB'(AFULL_LEVEL);
    localparam logic [LB-1:0] AEMPTY_L = LB'(AEMPTY_LEVEL);

    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS-1:0] rd_ptr;
    logic [LB-1:0]         count;
    logic                  full;
    logic                  empty;
    logic                  write_ok;
    logic                  read_ok;
    logic                  overflow_pulse;
    logic                  underflow_pulse;

    // Full gating looks only at registered state, so a concurrent read never frees a slot
    // for a write in the same cycle, and an empty FIFO never bypasses write data to the reader.
    assign full     = (count == CAPACITY);
    assign empty    = (count == '0);
    assign write_ok = write_i & ~full & ~flush_i;
    assign read_ok  = read_i & ~empty & ~flush_i;

    fifo_ram #(
        .DATA_BITS (DATA_BITS),
        .ADDR_BITS (DEPTH_BITS)
    ) u_ram (
        .clock      (clock),
        .write_en   (write_ok),
        .write_addr (wr_ptr),
        .write_data (write_data_i),
        .read_addr  (rd_ptr),
        .read_data  (read_data_o)
    );

    // Pointer and count update; flush empties the FIFO without touching the array.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (write_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (read_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (write_ok && !read_ok) begin
                count <= count + 1'b1;
            end else if (read_ok && !write_ok) begin
                count <= count - 1'b1;
            end
        end
    end

    assign write_ready_o  = ~full;
    assign read_ready_o   = ~empty;
    assign level_o        = count;
    assign almost_full_o  = (count >= AFULL_L);
    assign almost_empty_o = (count <= AEMPTY_L);

    assign overflow_pulse  = write_i & full & ~flush_i;
    assign underflow_pulse = read_i & empty & ~flush_i;

`ifdef FIFO_STICKY_ERRORS_EN
    logic sticky_overflow;
    logic sticky_underflow;

    // A new error in the same cycle as a clear wins; only reset clears, not flush.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sticky_overflow  <= 1'b0;
            sticky_underflow <= 1'b0;
        end else begin
            if (overflow_pulse) begin
                sticky_overflow <= 1'b1;
            end else if (error_clear_i) begin
                sticky_overflow <= 1'b0;
            end
            if (underflow_pulse) begin
                sticky_underflow <= 1'b1;
            end else if (error_clear_i) begin
                sticky_underflow <= 1'b0;
            end
        end
    end

    assign error_overflow_o  = overflow_pulse | sticky_overflow;
    assign error_underflow_o = underflow_pulse | sticky_underflow;
`else
    logic unused_error_clear;
    assign unused_error_clear = error_clear_i;

    assign error_overflow_o  = overflow_pulse;
    assign error_underflow_o = underflow_pulse;
`endif

endmodule

// File: tb/tb_fifo_level.sv
// Scoreboard bench for fifo_level (DATA_BITS=8, DEPTH_BITS=2, AFULL_LEVEL=3, AEMPTY_LEVEL=1).
// The driver applies one set of inputs per cycle, asks a queue-based reference model for the
// outputs that cycle must show, and pushes them; the monitor pops and compares on the falling edge.
module tb_fifo_level;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       flush_i = 1'b0;
    logic       write_i = 1'b0;
    logic [7:0] write_data_i = 8'h00;
    logic       write_ready_o;
    logic       read_i = 1'b0;
    logic [7:0] read_data_o;
    logic       read_ready_o;
    logic [2:0] level_o;
    logic       almost_full_o;
    logic       almost_empty_o;
    logic       error_clear_i = 1'b0;
    logic       error_overflow_o;
    logic       error_underflow_o;

    int checks = 0;
    int failures = 0;

    fifo_level #(
        .DATA_BITS    (8),
        .DEPTH_BITS   (2),
        .AFULL_LEVEL  (3),
        .AEMPTY_LEVEL (1)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .flush_i           (flush_i),
        .write_i           (write_i),
        .write_data_i      (write_data_i),
        .write_ready_o     (write_ready_o),
        .read_i            (read_i),
        .read_data_o       (read_data_o),
        .read_ready_o      (read_ready_o),
        .level_o           (level_o),
        .almost_full_o     (almost_full_o),
        .almost_empty_o    (almost_empty_o),
        .error_clear_i     (error_clear_i),
        .error_overflow_o  (error_overflow_o),
        .error_underflow_o (error_underflow_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         step;
        logic [2:0] level;
        logic       wr_rdy;
        logic       rd_rdy;
        logic       afull;
        logic       aempty;
        logic       ovf;
        logic       unf;
        logic       data_valid;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: contents as a plain queue, plus sticky error bits.
    logic [7:0] model_q[$];
    logic       model_sticky_ovf = 1'b0;
    logic       model_sticky_unf = 1'b0;
    int         step_no = 0;

`ifdef FIFO_STICKY_ERRORS_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    task automatic check(input string name, input int step, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s step=%0d got=%0d expected=%0d", name, step, act, expv);
        end
    endtask

    // Drive one cycle of inputs, record expected outputs for that cycle, advance the model.
    task automatic cycle(input bit rst, input bit fl, input bit wr, input logic [7:0] wd,
                         input bit rd, input bit clr);
        exp_t e;
        int   n;
        bit   full;
        bit   empty;
        bit   ovf;
        bit   unf;
        @(posedge clock);
        #1;
        reset         = rst;
        flush_i       = fl;
        write_i       = wr;
        write_data_i  = wd;
        read_i        = rd;
        error_clear_i = clr;
        if (rst) begin
            model_q.delete();
            model_sticky_ovf = 1'b0;
            model_sticky_unf = 1'b0;
        end
        n     = model_q.size();
        full  = (n == 4);
        empty = (n == 0);
        ovf   = wr && full && !fl;
        unf   = rd && empty && !fl;
        e.step       = step_no;
        e.level      = 3'(n);
        e.wr_rdy     = !full;
        e.rd_rdy     = !empty;
        e.afull      = (n >= 3);
        e.aempty     = (n <= 1);
        e.ovf        = ovf | (STICKY & model_sticky_ovf);
        e.unf        = unf | (STICKY & model_sticky_unf);
        e.data_valid = rd && !empty;
        e.data       = empty ? 8'h00 : model_q[0];
        exp_q.push_back(e);
        step_no++;
        if (!rst) begin
            if (fl) begin
                model_q.delete();
            end else begin
                if (rd && !empty) void'(model_q.pop_front());
                if (wr && !full) model_q.push_back(wd);
            end
            model_sticky_ovf = ovf ? 1'b1 : (clr ? 1'b0 : model_sticky_ovf);
            model_sticky_unf = unf ? 1'b1 : (clr ? 1'b0 : model_sticky_unf);
        end
    endtask

    task automatic idle();
        cycle(0, 0, 0, 8'h00, 0, 0);
    endtask

    task automatic wr(input logic [7:0] d);
        cycle(0, 0, 1, d, 0, 0);
    endtask

    task automatic rd();
        cycle(0, 0, 0, 8'h00, 1, 0);
    endtask

    // Monitor: compare the DUT against whatever the driver queued for this cycle.
    always @(negedge clock) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("level", e.step, int'(level_o), int'(e.level));
            check("write_ready", e.step, int'(write_ready_o), int'(e.wr_rdy));
            check("read_ready", e.step, int'(read_ready_o), int'(e.rd_rdy));
            check("almost_full", e.step, int'(almost_full_o), int'(e.afull));
            check("almost_empty", e.step, int'(almost_empty_o), int'(e.aempty));
            check("overflow", e.step, int'(error_overflow_o), int'(e.ovf));
            check("underflow", e.step, int'(error_underflow_o), int'(e.unf));
            if (e.data_valid) begin
                check("read_data", e.step, int'(read_data_o), int'(e.data));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and fill to full, then overflow with 88.
        cycle(1, 0, 0, 8'h00, 0, 0);
        cycle(1, 0, 0, 8'h00, 0, 0);
        wr(65); wr(66); wr(67); wr(68);
        wr(88);
        idle();
        // Drain, then underflow.
        rd(); rd(); rd(); rd();
        rd();
        idle();
        // Streaming at level 1: read and write every cycle.
        wr(65);
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 1, 8'(66 + i), 1, 0);
        end
        rd();
        idle();
        // Full with simultaneous read+write of 99.
        wr(1); wr(2); wr(3); wr(4);
        cycle(0, 0, 1, 8'd99, 1, 0);
        rd(); rd(); rd();
        // Empty with simultaneous read+write of 42.
        cycle(0, 0, 1, 8'd42, 1, 0);
        rd();
        idle();
        // Flush with a concurrent write (and a read), then reuse.
        wr(10); wr(11); wr(12);
        cycle(0, 1, 1, 8'd77, 1, 0);
        idle();
        wr(70);
        rd();
        // Flush while empty with strobes: no underflow/overflow.
        cycle(0, 1, 1, 8'd5, 1, 0);
        idle();
        // Error persistence and clear behaviour (pulses only in the default build).
        wr(1); wr(2); wr(3); wr(4);
        wr(5);
        for (int i = 0; i < 5; i++) idle();
        cycle(0, 0, 0, 8'h00, 0, 1);
        idle();
        cycle(0, 0, 1, 8'd6, 0, 1);
        idle();
        idle();
        cycle(0, 1, 0, 8'h00, 0, 0);
        idle();
        // Reset mid-stream at level 2.
        wr(20); wr(21);
        cycle(1, 0, 0, 8'h00, 0, 0);
        idle();
        rd();
        idle();
        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            bit r_fl;
            bit r_wr;
            bit r_rd;
            bit r_clr;
            r_fl  = ($urandom_range(0, 29) == 0);
            r_wr  = ($urandom_range(0, 99) < 55);
            r_rd  = ($urandom_range(0, 99) < 50);
            r_clr = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 149) == 0) begin
                cycle(1, 0, 0, 8'h00, 0, 0);
            end else begin
                cycle(0, r_fl, r_wr, 8'($urandom), r_rd, r_clr);
            end
        end
        idle();
        @(posedge clock);
        @(negedge clock);
        @(negedge clock);
        check("scoreboard_drained", step_no, exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
